// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Register-file write-back arbiter. Loads write straight through;
//               ALU results are queued in a FIFO and drained when no load is
//               present. Optional pending-write hazard compare: WB_HAZARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    input  logic [7:0]             ld_data,
    output logic                   ld_ready,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_addr,
    input  logic [7:0]             alu_data,
    output logic                   alu_ready,
    output logic                   wr_en,
    output logic [AW-1:0]          wr_addr,
    output logic [7:0]             wr_data,
    output logic [$clog2(DEPTH):0] count,
    input  logic [AW-1:0]          rd_addrA,
    input  logic [AW-1:0]          rd_addrB,
    output logic                   hit_a,
    output logic                   hit_b
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);

    logic [AW+7:0]      r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic               w_full;
    logic               w_nonempty;
    logic               w_push;
    logic               w_pop;

    assign w_nonempty = (count != '0);
    assign w_full     = (count == c_full);
    assign ld_ready   = !reset;
    assign alu_ready  = !reset && !w_full;
    assign w_push     = alu_valid && alu_ready;
    // A load always wins the write port; the queue only drains on load-free edges.
    assign w_pop      = !reset && !ld_valid && w_nonempty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {alu_addr, alu_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            count    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ld_valid) begin
                wr_en   <= 1'b1;
                wr_addr <= ld_addr;
                wr_data <= ld_data;
            end else if (w_nonempty) begin
                wr_en              <= 1'b1;
                {wr_addr, wr_data} <= r_mem[r_rd_ptr];
            end else begin
                wr_en <= 1'b0;
            end
        end
    end

`ifdef WB_HAZARD_EN
    logic [DEPTH-1:0] w_slot_hit_a;
    logic [DEPTH-1:0] w_slot_hit_b;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_slot
            logic [c_ptr_w-1:0] w_offset;
            logic               w_valid;
            // A slot holds a live entry when its distance from the head is below the occupancy.
            assign w_offset        = c_ptr_w'(g) - r_rd_ptr;
            assign w_valid         = ({1'b0, w_offset} < count);
            assign w_slot_hit_a[g] = w_valid && (r_mem[g][AW+7:8] == rd_addrA);
            assign w_slot_hit_b[g] = w_valid && (r_mem[g][AW+7:8] == rd_addrB);
        end
    endgenerate

    assign hit_a = (wr_en && (wr_addr == rd_addrA)) || (|w_slot_hit_a);
    assign hit_b = (wr_en && (wr_addr == rd_addrB)) || (|w_slot_hit_b);
`else
    logic w_unused_rd;
    assign w_unused_rd = ^{rd_addrA, rd_addrB};
    assign hit_a       = 1'b0;
    assign hit_b       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Self-checking bench for wb_arbiter: vector table, directed
//               corner sequences and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [7:0]    alu_data;
    logic          alu_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [$clog2(DEPTH):0] count;
    logic [AW-1:0] rd_addrA;
    logic [AW-1:0] rd_addrB;
    logic          hit_a;
    logic          hit_b;

    always #5 clk = ~clk;

    wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .count(count),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .hit_a(hit_a), .hit_b(hit_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: pending ALU results as a plain queue plus the last write.
    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } ent_t;
    ent_t          q[$];
    logic          m_en   = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_data = '0;
    bit            m_pushed;

    typedef struct {
        logic          rst;
        logic          ldv;
        logic [AW-1:0] lda;
        logic [7:0]    ldd;
        logic          aluv;
        logic [AW-1:0] alua;
        logic [7:0]    alud;
        logic          en;
        logic [AW-1:0] wa;
        logic [7:0]    wd;
        int            cnt;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int model_hit(input logic [AW-1:0] ra);
        int h;
        h = 0;
`ifdef WB_HAZARD_EN
        if (m_en && m_addr == ra) h = 1;
        foreach (q[i]) if (q[i].a == ra) h = 1;
`endif
        return h;
    endfunction

    // Called 1 time unit after an edge with inputs already driven.
    task automatic step();
        ent_t e;
        bit   can_push;
        #1;
        check("ld_ready", int'(ld_ready), int'(!reset));
        check("alu_ready", int'(alu_ready), int'(!reset && q.size() < DEPTH));
        check("hit_a", int'(hit_a), model_hit(rd_addrA));
        check("hit_b", int'(hit_b), model_hit(rd_addrB));
        m_pushed = 0;
        if (reset) begin
            q.delete();
            m_en = 0; m_addr = '0; m_data = '0;
        end else begin
            can_push = alu_valid && (q.size() < DEPTH);
            if (ld_valid) begin
                m_en = 1; m_addr = ld_addr; m_data = ld_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_en = 1; m_addr = e.a; m_data = e.d;
            end else begin
                m_en = 0;
            end
            if (can_push) begin
                e.a = alu_addr; e.d = alu_data;
                q.push_back(e);
                m_pushed = 1;
            end
        end
        @(posedge clk);
        #1;
        check("wr_en", int'(wr_en), int'(m_en));
        check("wr_addr", int'(wr_addr), int'(m_addr));
        check("wr_data", int'(wr_data), int'(m_data));
        check("count", int'(count), q.size());
    endtask

    task automatic idle_inputs();
        reset = 0; ld_valid = 0; alu_valid = 0;
        ld_addr = '0; ld_data = '0; alu_addr = '0; alu_data = '0;
    endtask

    function automatic vec_t mk(input logic rst, input logic ldv, input int lda, input int ldd,
                                input logic aluv, input int alua, input int alud,
                                input logic en, input int wa, input int wd, input int cnt);
        vec_t v;
        v.rst = rst; v.ldv = ldv; v.lda = AW'(lda); v.ldd = 8'(ldd);
        v.aluv = aluv; v.alua = AW'(alua); v.alud = 8'(alud);
        v.en = en; v.wa = AW'(wa); v.wd = 8'(wd); v.cnt = cnt;
        return v;
    endfunction

    initial begin
        logic [7:0] drained[$];
        int         k;
        int         exp_hit;

        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        vecs[1]  = mk(0, 1, 5, 8'hA7, 0, 0, 8'h00, 1, 5, 8'hA7, 0);
        vecs[2]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 5, 8'hA7, 0);
        vecs[3]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 5, 8'hA7, 1);
        vecs[4]  = mk(0, 0, 0, 8'h00, 1, 2, 8'h22, 1, 1, 8'h11, 1);
        vecs[5]  = mk(0, 0, 0, 8'h00, 1, 3, 8'h33, 1, 2, 8'h22, 1);
        vecs[6]  = mk(0, 0, 0, 8'h00, 1, 4, 8'h44, 1, 3, 8'h33, 1);
        vecs[7]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 8'h44, 0);
        vecs[8]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4, 8'h44, 0);
        vecs[9]  = mk(0, 1, 0, 8'h5A, 1, 7, 8'h77, 1, 0, 8'h5A, 1);
        vecs[10] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 7, 8'h77, 0);
        vecs[11] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);

        idle_inputs();
        rd_addrA = '0; rd_addrB = '0;
        reset = 1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            reset = vecs[i].rst; ld_valid = vecs[i].ldv; ld_addr = vecs[i].lda; ld_data = vecs[i].ldd;
            alu_valid = vecs[i].aluv; alu_addr = vecs[i].alua; alu_data = vecs[i].alud;
            step();
            check("vec_wr_en", int'(wr_en), int'(vecs[i].en));
            check("vec_wr_addr", int'(wr_addr), int'(vecs[i].wa));
            check("vec_wr_data", int'(wr_data), int'(vecs[i].wd));
            check("vec_count", int'(count), vecs[i].cnt);
        end

        // Loads starve the queue while five ALU results are offered.
        idle_inputs();
        k = 0;
        for (int c = 0; c < 6; c++) begin
            ld_valid = 1; ld_addr = AW'(c); ld_data = 8'(8'hC0 + c);
            alu_valid = (k < 5); alu_addr = AW'(k + 1); alu_data = 8'(8'h90 + k);
            step();
            if (m_pushed) k++;
        end
        check("starve_count", int'(count), 4);
        check("starve_pushed", k, 4);
        check("starve_alu_ready", int'(alu_ready), 0);

        // Full queue: pop happens, the held fifth result waits one edge.
        ld_valid = 0;
        #1;
        check("full_pop_alu_ready", int'(alu_ready), 0);
        step();
        if (wr_en) drained.push_back(wr_data);
        check("full_pop_count", int'(count), 3);
        for (int c = 0; c < 10; c++) begin
            alu_valid = (k < 5); alu_addr = AW'(k + 1); alu_data = 8'(8'h90 + k);
            step();
            if (m_pushed) k++;
            if (wr_en) drained.push_back(wr_data);
        end
        check("drain_len", drained.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check("drain_order", (i < drained.size()) ? int'(drained[i]) : -1, 8'h90 + i);
        end

        // Hazard: queue holds addr 6.
        idle_inputs();
        ld_valid = 1; ld_addr = 1; alu_valid = 1; alu_addr = 6; alu_data = 8'h66;
        step();
        alu_valid = 0;
        rd_addrA = 6; rd_addrB = 2;
`ifdef WB_HAZARD_EN
        exp_hit = 1;
`else
        exp_hit = 0;
`endif
        #1;
        check("hazard_hit_a", int'(hit_a), exp_hit);
        check("hazard_hit_b", int'(hit_b), 0);
        step();

        // Reset with three entries queued: nothing is written afterwards.
        for (int c = 0; c < 2; c++) begin
            alu_valid = 1; alu_addr = AW'(c); alu_data = 8'(8'hE0 + c);
            step();
        end
        alu_valid = 0;
        check("pre_reset_count", int'(count), 3);
        reset = 1; ld_valid = 0;
        step();
        check("reset_count", int'(count), 0);
        check("reset_wr_en", int'(wr_en), 0);
        reset = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_reset_no_write", int'(wr_en), 0);
        end

        // Randomized traffic.
        for (int c = 0; c < 500; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            ld_valid  = ($urandom_range(0, 2) == 0);
            ld_addr   = AW'($urandom);
            ld_data   = 8'($urandom);
            alu_valid = ($urandom_range(0, 2) != 0);
            alu_addr  = AW'($urandom);
            alu_data  = 8'($urandom);
            rd_addrA  = AW'($urandom);
            rd_addrB  = AW'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, meaning ALU result queue depth in entries (power of 2, at least 2).
REQ-002 Parameter AW, default 3, meaning register address width (8 registers).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port ld_valid  input  1  memory load result valid.
REQ-006 Port ld_addr  input  AW  load destination register.
REQ-007 Port ld_data  input  8  load result data.
REQ-008 Port ld_ready  output  1  load accepted this cycle; combinational, equals !reset.
REQ-009 Port alu_valid  input  1  ALU result valid.
REQ-010 Port alu_addr  input  AW  ALU destination register.
REQ-011 Port alu_data  input  8  ALU result data.
REQ-012 Port alu_ready  output  1  combinational, equals !reset && !full.
REQ-013 Port wr_en  output  1  registered write enable to the register file.
REQ-014 Port wr_addr  output  AW  registered write address.
REQ-015 Port wr_data  output  8  registered write data.
REQ-016 Port count  output  $clog2(DEPTH)+1  registered queue occupancy, 0..DEPTH.
REQ-017 Ports rd_addrA, rd_addrB  input  AW each  register file read addresses, used for hazard check.
REQ-018 Ports hit_a, hit_b  output  1 each  pending-write hazard flags for rd_addrA/rd_addrB.

Function
REQ-019 ALU handshake: an entry is pushed at a rising edge where alu_valid && alu_ready; otherwise alu inputs are ignored.
REQ-020 Load handshake: a load is accepted at every rising edge where ld_valid is high and reset is low; loads are never buffered.
REQ-021 Write select per edge: if ld_valid, write outputs load {addr,data}; else if count>0, write outputs pop the queue head; else wr_en<=0 and wr_addr/wr_data hold.
REQ-022 Latency: a load accepted at edge N is on wr_* from edge N to edge N+1 (1 cycle); an ALU entry pushed at edge N reaches wr_* at edge N+1 at earliest.
REQ-023 wr_en is high for exactly one cycle per accepted load or popped entry; there is at most one write per cycle.
REQ-024 Queue order is strict FIFO; entries leave in push order, and loads may overtake queued ALU entries.
REQ-025 Push and pop in the same edge: both take effect; count stays unchanged.
REQ-026 Full (count==DEPTH): alu_ready=0 even if a pop occurs that edge; the held alu_valid is accepted on a later edge.
REQ-027 Empty (count==0) with no load: wr_en<=0; no underflow; pointers unchanged.
REQ-028 Read and write pointers wrap modulo DEPTH; count is exact across wrap.
REQ-029 Continuous ld_valid starves the queue indefinitely; the queue contents are preserved and no entry is dropped.
REQ-030 All register addresses, including 0, are written normally.

Reset
REQ-031 While reset is high at an edge: count<=0, pointers<=0, wr_en<=0, wr_addr<=0, wr_data<=0; queue contents are don't-care.
REQ-032 While reset is high, ld_ready=0 and alu_ready=0; inputs are not accepted.
REQ-033 Reset mid-operation discards all queued entries and any in-flight write; the first post-reset edge behaves as from empty.

Configuration
REQ-034 Macro WB_HAZARD_EN: when defined, hit_a is combinationally 1 if (wr_en && wr_addr==rd_addrA) or any valid queue entry has addr==rd_addrA; hit_b is the same for rd_addrB.
REQ-035 Without WB_HAZARD_EN, hit_a and hit_b are tied 0 and no compare logic exists; ports remain present.

Verification
REQ-036 Reset, then load addr=5 data=0xA7 for one cycle -> next cycle wr_en=1, wr_addr=5, wr_data=0xA7, then wr_en=0.
REQ-037 Push ALU 1/0x11, 2/0x22, 3/0x33, 4/0x44 back-to-back with ld_valid=0 -> writes in order 1,2,3,4 on consecutive cycles; count peaks at 1.
REQ-038 Hold ld_valid=1 for 6 cycles while pushing 5 ALU results -> count reaches 4, alu_ready=0 and fifth held; after ld_valid drops, 5 ALU writes follow in push order.
REQ-039 Full queue with simultaneous pop and alu_valid -> no push that edge, count goes 4->3, pushed next edge.
REQ-040 WB_HAZARD_EN defined, queue holds addr 6, rd_addrA=6, rd_addrB=2 -> hit_a=1, hit_b=0; undefined -> both 0.
REQ-041 Assert reset with count=3 -> next edge count=0, wr_en=0; no queued entry is written after release.
